// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with RV32I field/immediate/control decode and
// saturating stall/flush event counters.
module if_id_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          instr_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [31:0]          instr_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [6:0]           opcode,
    output logic [4:0]           rd,
    output logic [2:0]           funct3,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [6:0]           funct7,
    output logic [XLEN-1:0]      imm,
    output logic [2:0]           imm_type,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 jump,
    output logic                 alu_src,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_kind_e;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    opcode_e            op;
    imm_kind_e          kind;
    logic               known;
    logic               legal;
    logic               ctl_en;
    logic [5:0]         ctl;
    logic signed [31:0] imm32;

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_out <= NOP_INSTR;
            pc_out    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            instr_out <= NOP_INSTR;
            out_valid <= 1'b0;
        end else if (!stall) begin
            instr_out <= instr_in;
            pc_out    <= pc_in;
            out_valid <= in_valid;
        end
    end

    // Counters see stall/flush independently, so a combined cycle bumps both.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush && flush_count != '1) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

    assign opcode = instr_out[6:0];
    assign rd     = instr_out[11:7];
    assign funct3 = instr_out[14:12];
    assign rs1    = instr_out[19:15];
    assign rs2    = instr_out[24:20];
    assign funct7 = instr_out[31:25];
    assign op     = opcode_e'(instr_out[6:0]);

    // ctl = {reg_write, mem_read, mem_write, branch, jump, alu_src}
    always_comb begin
        kind  = IMM_NONE;
        known = 1'b0;
        ctl   = '0;
        case (op)
            OP_REG:    begin known = 1'b1;                  ctl = 6'b100000; end
            OP_IMM:    begin known = 1'b1; kind = IMM_I;    ctl = 6'b100001; end
            OP_LOAD:   begin known = 1'b1; kind = IMM_I;    ctl = 6'b110001; end
            OP_JALR:   begin known = 1'b1; kind = IMM_I;    ctl = 6'b100011; end
            OP_STORE:  begin known = 1'b1; kind = IMM_S;    ctl = 6'b001001; end
            OP_BRANCH: begin known = 1'b1; kind = IMM_B;    ctl = 6'b000100; end
            OP_LUI,
            OP_AUIPC:  begin known = 1'b1; kind = IMM_U;    ctl = 6'b100001; end
            OP_JAL:    begin known = 1'b1; kind = IMM_J;    ctl = 6'b100011; end
            default:   ;
        endcase
    end

    assign legal   = known && (instr_out[1:0] == 2'b11);
    assign illegal = out_valid && !legal;
    assign ctl_en  = out_valid && legal;
    assign {reg_write, mem_read, mem_write, branch, jump, alu_src} = ctl & {6{ctl_en}};

    always_comb begin
        imm32 = '0;
        case (kind)
            IMM_I:   imm32 = {{20{instr_out[31]}}, instr_out[31:20]};
            IMM_S:   imm32 = {{20{instr_out[31]}}, instr_out[31:25], instr_out[11:7]};
            IMM_B:   imm32 = {{20{instr_out[31]}}, instr_out[7], instr_out[30:25],
                              instr_out[11:8], 1'b0};
            IMM_U:   imm32 = {instr_out[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr_out[31]}}, instr_out[19:12], instr_out[20],
                              instr_out[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm      = XLEN'(imm32);
    assign imm_type = kind;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Bench for if_id_decode_stage: opcode-class reference model checked every
// cycle, plus hand-computed expectations at chosen points.
module tb_if_id_decode_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] instr_in, pc_in;

    logic        out_valid, reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;
    logic [31:0] instr_out, pc_out, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, imm_type;
    logic [15:0] stall_count, flush_count;

    logic        s_out_valid, s_reg_write, s_mem_read, s_mem_write, s_branch, s_jump, s_alu_src, s_illegal;
    logic [31:0] s_instr_out, s_pc_out, s_imm;
    logic [6:0]  s_opcode, s_funct7;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [2:0]  s_funct3, s_imm_type;
    logic [2:0]  s_stall_count, s_flush_count;

    always #5 clock = ~clock;

    if_id_decode_stage #(.XLEN(32), .NOP_INSTR(32'h00000013), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_valid(out_valid), .instr_out(instr_out), .pc_out(pc_out),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .imm(imm), .imm_type(imm_type), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .alu_src(alu_src),
        .illegal(illegal), .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    if_id_decode_stage #(.XLEN(32), .NOP_INSTR(32'h00000013), .CNT_WIDTH(3)) dut_small (
        .clock(clock), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_valid(s_out_valid), .instr_out(s_instr_out), .pc_out(s_pc_out),
        .opcode(s_opcode), .rd(s_rd), .funct3(s_funct3), .rs1(s_rs1), .rs2(s_rs2), .funct7(s_funct7),
        .imm(s_imm), .imm_type(s_imm_type), .reg_write(s_reg_write), .mem_read(s_mem_read),
        .mem_write(s_mem_write), .branch(s_branch), .jump(s_jump), .alu_src(s_alu_src),
        .illegal(s_illegal), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    int tests = 0;
    int fails = 0;
    int lit_id = 0;
    bit armed = 1'b0;

    logic [31:0] m_instr, m_pc;
    logic        m_valid;
    int          m_sc, m_fc, m_ssc, m_sfc;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  itype;
        logic [5:0]  ctl;   // {reg_write, mem_read, mem_write, branch, jump, alu_src}
        logic        ill;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w, input logic v);
        dec_t  d;
        string cls;
        int    val;
        d   = '0;
        val = 0;
        case (w[6:0])
            7'b0110011: cls = "R";
            7'b0010011: cls = "I";
            7'b0000011: cls = "LOAD";
            7'b1100111: cls = "JALR";
            7'b0100011: cls = "S";
            7'b1100011: cls = "B";
            7'b0110111, 7'b0010111: cls = "U";
            7'b1101111: cls = "J";
            default:    cls = "";
        endcase
        if (w[1:0] != 2'b11) cls = "";
        if (cls == "I" || cls == "LOAD" || cls == "JALR") begin
            val = int'($signed(w[31:20])); d.itype = 3'd1;
        end else if (cls == "S") begin
            val = int'($signed({w[31:25], w[11:7]})); d.itype = 3'd2;
        end else if (cls == "B") begin
            val = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); d.itype = 3'd3;
        end else if (cls == "U") begin
            val = int'({w[31:12], 12'h000}); d.itype = 3'd4;
        end else if (cls == "J") begin
            val = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); d.itype = 3'd5;
        end
        d.imm = 32'(val);
        if (v && cls != "") begin
            d.ctl[5] = (cls != "S" && cls != "B");
            d.ctl[4] = (cls == "LOAD");
            d.ctl[3] = (cls == "S");
            d.ctl[2] = (cls == "B");
            d.ctl[1] = (cls == "J" || cls == "JALR");
            d.ctl[0] = (cls != "R" && cls != "B");
        end
        d.ill = v && (cls == "");
        return d;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_instr <= NOP; m_pc <= '0; m_valid <= 1'b0;
            m_sc <= 0; m_fc <= 0; m_ssc <= 0; m_sfc <= 0;
        end else begin
            if (flush) begin
                m_instr <= NOP; m_valid <= 1'b0;
            end else if (!stall) begin
                m_instr <= instr_in; m_pc <= pc_in; m_valid <= in_valid;
            end
            if (stall) begin
                m_sc  <= (m_sc  < 65535) ? m_sc  + 1 : m_sc;
                m_ssc <= (m_ssc < 7)     ? m_ssc + 1 : m_ssc;
            end
            if (flush) begin
                m_fc  <= (m_fc  < 65535) ? m_fc  + 1 : m_fc;
                m_sfc <= (m_sfc < 7)     ? m_sfc + 1 : m_sfc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            dec_t e;
            logic [31:0] fld;
            e   = decode(m_instr, m_valid);
            fld = {m_instr[6:0], m_instr[11:7], m_instr[14:12], m_instr[19:15], m_instr[24:20], m_instr[31:25]};
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("instr_out", instr_out, m_instr);
            chk("pc_out", pc_out, m_pc);
            chk("fields", {opcode, rd, funct3, rs1, rs2, funct7}, fld);
            if (m_valid) begin
                chk("imm", imm, e.imm);
                chk("imm_type", 32'(imm_type), 32'(e.itype));
            end
            chk("controls", 32'({reg_write, mem_read, mem_write, branch, jump, alu_src}), 32'(e.ctl));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("stall_count", 32'(stall_count), 32'(m_sc));
            chk("flush_count", 32'(flush_count), 32'(m_fc));
            chk("s_state", {s_instr_out[30:0], s_out_valid}, {m_instr[30:0], m_valid});
            chk("s_pc_out", s_pc_out, m_pc);
            chk("s_fields", {s_opcode, s_rd, s_funct3, s_rs1, s_rs2, s_funct7}, fld);
            if (m_valid) chk("s_imm", s_imm ^ 32'(s_imm_type), e.imm ^ 32'(e.itype));
            chk("s_controls", 32'({s_reg_write, s_mem_read, s_mem_write, s_branch, s_jump, s_alu_src, s_illegal}),
                32'({e.ctl, e.ill}));
            chk("s_stall_count", 32'(s_stall_count), 32'(m_ssc));
            chk("s_flush_count", 32'(s_flush_count), 32'(m_sfc));

            case (lit_id)
                1: begin
                    chk("rst_valid", 32'(out_valid), 32'd0);
                    chk("rst_instr", instr_out, 32'h00000013);
                    chk("rst_pc", pc_out, 32'h0);
                    chk("rst_ctl", 32'({reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}), 32'd0);
                    chk("rst_counts", {stall_count, flush_count}, 32'd0);
                end
                2: begin
                    chk("addi_rd", 32'(rd), 32'd1);
                    chk("addi_rs1", 32'(rs1), 32'd2);
                    chk("addi_imm", imm, 32'h00000005);
                    chk("addi_type", 32'(imm_type), 32'd1);
                    chk("addi_rw_as", 32'({reg_write, alu_src}), 32'b11);
                    chk("addi_pc", pc_out, 32'h4);
                end
                3: begin
                    chk("sw_imm", imm, 32'hFFFFFFFC);
                    chk("sw_mem_write", 32'(mem_write), 32'd1);
                end
                4: begin
                    chk("beq_imm", imm, 32'hFFFFFFF8);
                    chk("beq_branch_rw", 32'({branch, reg_write}), 32'b10);
                end
                5: begin
                    chk("jal_imm", imm, 32'h00000800);
                    chk("jal_jump_rw", 32'({jump, reg_write}), 32'b11);
                end
                6: begin
                    chk("stall_instr", instr_out, 32'h123451B7);
                    chk("stall_imm", imm, 32'h12345000);
                    chk("stall_cnt3", 32'(stall_count), 32'd3);
                end
                7: begin
                    chk("fl_valid", 32'(out_valid), 32'd0);
                    chk("fl_instr", instr_out, 32'h00000013);
                    chk("fl_flush_cnt", 32'(flush_count), 32'd1);
                    chk("fl_stall_cnt", 32'(stall_count), 32'd4);
                end
                8: begin
                    chk("ill_flag", 32'({out_valid, illegal}), 32'b11);
                    chk("ill_ctl", 32'({reg_write, mem_read, mem_write, branch, jump, alu_src}), 32'd0);
                end
                9: begin
                    chk("rst2_state", {instr_out[30:0], out_valid}, {31'h13, 1'b0});
                    chk("rst2_pc", pc_out, 32'h0);
                    chk("rst2_counts", {stall_count, flush_count}, 32'd0);
                end
                10: begin
                    chk("lw_mem_read", 32'({mem_read, reg_write, alu_src}), 32'b111);
                    chk("lw_imm", imm, 32'h4);
                    chk("lw_rd", 32'(rd), 32'd5);
                end
                11: begin
                    chk("sat_small_stall", 32'(s_stall_count), 32'd7);
                    chk("big_stall10", 32'(stall_count), 32'd10);
                end
                12: begin
                    chk("sat_small_flush", 32'(s_flush_count), 32'd7);
                    chk("big_flush9", 32'(flush_count), 32'd9);
                end
                default: ;
            endcase
        end
    end

    task automatic step(input int id);
        @(posedge clock);
        #1 lit_id = id;
        @(negedge clock);
        #1 lit_id = 0;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] pc, input int id);
        instr_in = w;
        pc_in    = pc;
        step(id);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr_in = '0; pc_in = '0;
        @(posedge clock);
        #1 armed = 1'b1;
        step(1);
        reset = 1'b0;
        step(0);

        in_valid = 1'b1;
        load(32'h00510093, 32'h04, 2);   // addi x1,x2,5
        load(32'hFE512E23, 32'h08, 3);   // sw x5,-4(x2)
        load(32'hFE000CE3, 32'h0C, 4);   // beq x0,x0,-8
        load(32'h001000EF, 32'h10, 5);   // jal x1,2048
        load(32'h123451B7, 32'h14, 0);   // lui x3,0x12345

        stall = 1'b1;
        load(32'h002081B3, 32'h18, 0);
        load(32'h00412283, 32'h1C, 0);
        load(32'hFE512E23, 32'h20, 6);

        flush = 1'b1;
        load(32'h00510093, 32'h24, 7);
        flush = 1'b0; stall = 1'b0;
        load(32'h00510093, 32'h28, 0);
        load(32'hFFFFFFFF, 32'h2C, 8);

        reset = 1'b1; stall = 1'b1;
        load(32'h00510093, 32'h30, 9);
        reset = 1'b0; stall = 1'b0;
        load(32'h00412283, 32'h34, 10);  // lw x5,4(x2)

        load(32'h002081B3, 32'h38, 0);   // add
        load(32'h000080E7, 32'h3C, 0);   // jalr x1,0(x1)
        load(32'h00001517, 32'h40, 0);   // auipc
        load(32'h80000537, 32'h44, 0);   // lui, sign bit set
        load(32'h00000010, 32'h48, 0);   // low bits not 11
        load(32'h0000000B, 32'h4C, 0);   // unknown opcode
        in_valid = 1'b0;
        load(32'h00510093, 32'h50, 0);

        stall = 1'b1;
        repeat (9) load(32'h00000033, 32'h54, 0);
        load(32'h00000033, 32'h58, 11);
        stall = 1'b0; flush = 1'b1;
        repeat (8) load(32'h00000033, 32'h5C, 0);
        load(32'h00000033, 32'h60, 12);
        flush = 1'b0; in_valid = 1'b1;
        load(32'hFE000CE3, 32'h64, 0);
        step(0);

        @(negedge clock);
        #1 armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
